// File: rtl/sr_arb_pkg.sv
// Shared opcode and FSM state definitions for the SR command arbiter.
package sr_arb_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_RESET   = 2'b01;
    localparam logic [1:0] OP_SET     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/sr_cmd_arbiter_rr.sv
// Round-robin arbiter: one-hot grant starting the search at a rotating pointer
// that moves just past the winner whenever a grant is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] win_idx;
    logic          found;

    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_reg) + k) % N]) begin
                found   = 1'b1;
                win_idx = PW'((int'(ptr_reg) + k) % N);
                grant[(int'(ptr_reg) + k) % N] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (advance && found) begin
            ptr_next = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Arbitrates set/reset commands from NREQ requesters onto a shared SR flag bank,
// never driving S and R together. Optional err_cnt port: SR_CMD_ARB_ERRCNT_EN.
module sr_cmd_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [IW*NREQ-1:0]  req_idx,
    output logic [NREQ-1:0]     req_ready,
    output logic [NFLAG-1:0]    s_out,
    output logic [NFLAG-1:0]    r_out,
    output logic [NFLAG-1:0]    q_shadow,
    output logic [2:0]          grant_id,
    output logic                busy,
`ifdef SR_CMD_ARB_ERRCNT_EN
    output logic [7:0]          err_cnt,
    output logic                err
`else
    output logic                err
`endif
);

    state_t            state_reg, state_next;
    logic [1:0]        op_reg;
    logic [IW-1:0]     idx_reg;
    logic [2:0]        grant_id_reg;
    logic [NFLAG-1:0]  q_shadow_reg, q_shadow_next;

    logic [NREQ-1:0]   grant;
    logic              accept;
    logic [2:0]        winner;
    logic [1:0]        sel_op;
    logic [IW-1:0]     sel_idx;
    logic              idx_ok;
    logic              do_set;
    logic              do_reset;

    // Reset masks the handshake so no requester believes it was served.
    assign accept = (state_reg == ST_IDLE) && (|req_valid) && !rst;

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = accept ? grant : '0;

    always_comb begin
        winner  = '0;
        sel_op  = '0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                winner  = 3'(i);
                sel_op  = req_op[2*i +: 2];
                sel_idx = req_idx[IW*i +: IW];
            end
        end
    end

    assign idx_ok = int'(idx_reg) < NFLAG;

    always_comb begin
        state_next = state_reg;
        err        = 1'b0;
        do_set     = 1'b0;
        do_reset   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_next = ST_IDLE;
                case (op_reg)
                    OP_SET: begin
                        if (idx_ok) begin
                            do_set     = 1'b1;
                            state_next = ST_SETTLE;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    OP_RESET: begin
                        if (idx_ok) begin
                            do_reset   = 1'b1;
                            state_next = ST_SETTLE;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    OP_ILLEGAL: err = 1'b1;
                    default: ;
                endcase
            end
            ST_SETTLE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // do_set and do_reset are mutually exclusive, so S=R=1 cannot occur.
    for (genvar gi = 0; gi < NFLAG; gi++) begin : g_pulse
        assign s_out[gi] = do_set   && (idx_reg == IW'(gi));
        assign r_out[gi] = do_reset && (idx_reg == IW'(gi));
    end

    always_comb begin
        q_shadow_next = q_shadow_reg;
        for (int f = 0; f < NFLAG; f++) begin
            if (state_reg == ST_SETTLE && int'(idx_reg) == f) begin
                q_shadow_next[f] = (op_reg == OP_SET);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_NOP;
            idx_reg      <= '0;
            grant_id_reg <= '0;
            q_shadow_reg <= '0;
        end else begin
            state_reg    <= state_next;
            q_shadow_reg <= q_shadow_next;
            if (accept) begin
                op_reg       <= sel_op;
                idx_reg      <= sel_idx;
                grant_id_reg <= winner;
            end
        end
    end

    assign q_shadow = q_shadow_reg;
    assign grant_id = grant_id_reg;
    assign busy     = (state_reg != ST_IDLE);

`ifdef SR_CMD_ARB_ERRCNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (err && err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    // Without the counter, rejected commands are reported only by the err pulse.
`endif

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed per-cycle vector table plus a random-traffic invariant phase.
module tb_sr_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [15:0] req_idx;
    logic [3:0]  req_ready;
    logic [7:0]  s_out, r_out, q_shadow;
    logic [2:0]  grant_id;
    logic        busy, err;
`ifdef SR_CMD_ARB_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_cmd_arbiter #(.NREQ(4), .NFLAG(8), .IW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .s_out     (s_out),
        .r_out     (r_out),
        .q_shadow  (q_shadow),
        .grant_id  (grant_id),
        .busy      (busy),
`ifdef SR_CMD_ARB_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .err       (err)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  v;
        logic [7:0]  op;
        logic [15:0] idx;
        logic [3:0]  rdy;
        logic [7:0]  s;
        logic [7:0]  r;
        logic [7:0]  q;
        logic [2:0]  gid;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic rs, input logic [3:0] v,
                       input logic [7:0] op, input logic [15:0] idx,
                       input logic [3:0] rdy, input logic [7:0] s, input logic [7:0] r,
                       input logic [7:0] q, input logic [2:0] gid,
                       input logic bz, input logic er);
        vec_t t;
        t.name = nm; t.rst = rs; t.v = v; t.op = op; t.idx = idx;
        t.rdy = rdy; t.s = s; t.r = r; t.q = q; t.gid = gid; t.busy = bz; t.err = er;
        vecs.push_back(t);
    endtask

    initial begin
        logic [3:0] prev_rdy;
        logic [7:0] sr_or;

        //   name            rst v     op     idx       rdy   s      r      q      gid busy err
        add("rst_a",         1, 4'hF, 8'hAA, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("rst_b",         1, 4'hF, 8'hAA, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("set3_acc",      0, 4'h1, 8'h02, 16'h0003, 4'h1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("set3_issue",    0, 4'h0, 8'h02, 16'h0003, 4'h0, 8'h08, 8'h00, 8'h00, 0, 1, 0);
        add("set3_settle",   0, 4'h0, 8'h02, 16'h0003, 4'h0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        add("rst3_acc",      0, 4'h1, 8'h01, 16'h0003, 4'h1, 8'h00, 8'h00, 8'h08, 0, 0, 0);
        add("rst3_issue",    0, 4'h0, 8'h01, 16'h0003, 4'h0, 8'h00, 8'h08, 8'h08, 0, 1, 0);
        add("rst3_settle",   0, 4'h0, 8'h01, 16'h0003, 4'h0, 8'h00, 8'h00, 8'h08, 0, 1, 0);
        add("rst3_done",     0, 4'h0, 8'h01, 16'h0003, 4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("ptr_clear",     1, 4'h0, 8'h00, 16'h0000, 4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("rr0_acc",       0, 4'hF, 8'hAA, 16'h3210, 4'h1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("rr0_issue",     0, 4'hE, 8'hAA, 16'h3210, 4'h0, 8'h01, 8'h00, 8'h00, 0, 1, 0);
        add("rr0_settle",    0, 4'hE, 8'hAA, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        add("rr1_acc",       0, 4'hE, 8'hAA, 16'h3210, 4'h2, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        add("rr1_issue",     0, 4'hC, 8'hAA, 16'h3210, 4'h0, 8'h02, 8'h00, 8'h01, 1, 1, 0);
        add("rr1_settle",    0, 4'hC, 8'hAA, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h01, 1, 1, 0);
        add("rr2_acc",       0, 4'hC, 8'hAA, 16'h3210, 4'h4, 8'h00, 8'h00, 8'h03, 1, 0, 0);
        add("rr2_issue",     0, 4'h8, 8'hAA, 16'h3210, 4'h0, 8'h04, 8'h00, 8'h03, 2, 1, 0);
        add("rr2_settle",    0, 4'h8, 8'hAA, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h03, 2, 1, 0);
        add("rr3_acc",       0, 4'h8, 8'hAA, 16'h3210, 4'h8, 8'h00, 8'h00, 8'h07, 2, 0, 0);
        add("rr3_issue",     0, 4'h0, 8'hAA, 16'h3210, 4'h0, 8'h08, 8'h00, 8'h07, 3, 1, 0);
        add("rr3_settle",    0, 4'h0, 8'hAA, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h07, 3, 1, 0);
        add("rr_done",       0, 4'h0, 8'hAA, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h0F, 3, 0, 0);
        add("nop_acc",       0, 4'h2, 8'h00, 16'h0000, 4'h2, 8'h00, 8'h00, 8'h0F, 3, 0, 0);
        add("nop_issue",     0, 4'h0, 8'h00, 16'h0000, 4'h0, 8'h00, 8'h00, 8'h0F, 1, 1, 0);
        add("rrb2_acc",      0, 4'hF, 8'h55, 16'h3210, 4'h4, 8'h00, 8'h00, 8'h0F, 1, 0, 0);
        add("rrb2_issue",    0, 4'hB, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h04, 8'h0F, 2, 1, 0);
        add("rrb2_settle",   0, 4'hB, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h0F, 2, 1, 0);
        add("rrb3_acc",      0, 4'hB, 8'h55, 16'h3210, 4'h8, 8'h00, 8'h00, 8'h0B, 2, 0, 0);
        add("rrb3_issue",    0, 4'h3, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h08, 8'h0B, 3, 1, 0);
        add("rrb3_settle",   0, 4'h3, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h0B, 3, 1, 0);
        add("rrb0_acc",      0, 4'h3, 8'h55, 16'h3210, 4'h1, 8'h00, 8'h00, 8'h03, 3, 0, 0);
        add("rrb0_issue",    0, 4'h2, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h01, 8'h03, 0, 1, 0);
        add("rrb0_settle",   0, 4'h2, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h03, 0, 1, 0);
        add("rrb1_acc",      0, 4'h2, 8'h55, 16'h3210, 4'h2, 8'h00, 8'h00, 8'h02, 0, 0, 0);
        add("rrb1_issue",    0, 4'h0, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h02, 8'h02, 1, 1, 0);
        add("rrb1_settle",   0, 4'h0, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h02, 1, 1, 0);
        add("rrb_done",      0, 4'h0, 8'h55, 16'h3210, 4'h0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        add("ill_acc",       0, 4'h2, 8'h0C, 16'h0020, 4'h2, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        add("ill_issue",     0, 4'h0, 8'h0C, 16'h0020, 4'h0, 8'h00, 8'h00, 8'h00, 1, 1, 1);
        add("oor_acc",       0, 4'h2, 8'h08, 16'h0090, 4'h2, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        add("oor_issue",     0, 4'h0, 8'h08, 16'h0090, 4'h0, 8'h00, 8'h00, 8'h00, 1, 1, 1);
        add("oor_idle",      0, 4'h0, 8'h08, 16'h0090, 4'h0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        add("rmid_acc",      0, 4'h1, 8'h02, 16'h0005, 4'h1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        add("rmid_issue",    1, 4'h0, 8'h02, 16'h0005, 4'h0, 8'h20, 8'h00, 8'h00, 0, 1, 0);
        add("rmid_after",    0, 4'h0, 8'h02, 16'h0005, 4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("rmid_idle",     0, 4'h0, 8'h02, 16'h0005, 4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        rst = 1'b1; req_valid = '0; req_op = '0; req_idx = '0;
        repeat (2) @(posedge clk);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst       = vecs[n].rst;
            req_valid = vecs[n].v;
            req_op    = vecs[n].op;
            req_idx   = vecs[n].idx;
            #1;
            checks++;
            if (req_ready !== vecs[n].rdy || s_out !== vecs[n].s || r_out !== vecs[n].r ||
                q_shadow !== vecs[n].q || grant_id !== vecs[n].gid ||
                busy !== vecs[n].busy || err !== vecs[n].err) begin
                errors++;
                $display("FAIL %s: got rdy=%h s=%h r=%h q=%h gid=%0d busy=%b err=%b, want rdy=%h s=%h r=%h q=%h gid=%0d busy=%b err=%b",
                         vecs[n].name, req_ready, s_out, r_out, q_shadow, grant_id, busy, err,
                         vecs[n].rdy, vecs[n].s, vecs[n].r, vecs[n].q, vecs[n].gid,
                         vecs[n].busy, vecs[n].err);
            end else begin
                $display("vec %s: rdy=%h s=%h r=%h q=%h gid=%0d busy=%b err=%b",
                         vecs[n].name, req_ready, s_out, r_out, q_shadow, grant_id, busy, err);
            end
        end

        // Random traffic: requesters hold their command until accepted.
        prev_rdy = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 4; i++) begin
                if (prev_rdy[i] || !req_valid[i]) begin
                    req_valid[i]       = 1'($urandom_range(0, 1));
                    req_op[2*i +: 2]   = 2'($urandom_range(0, 3));
                    req_idx[4*i +: 4]  = 4'($urandom_range(0, 15));
                end
            end
            #1;
            sr_or = s_out | r_out;
            checks++;
            if ((s_out & r_out) != 8'h00 || $countones(sr_or) > 1 || $countones(req_ready) > 1) begin
                errors++;
                $display("FAIL invariant cycle %0d: s=%h r=%h rdy=%h, want s&r=0 and at most one pulse/ready",
                         c, s_out, r_out, req_ready);
            end
            if (req_ready != 4'h0) begin
                $display("rand cycle %0d: accept rdy=%h op=%h idx=%h", c, req_ready, req_op, req_idx);
            end
            prev_rdy = req_ready;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
